// File: rtl/pkt_hdr_serializer.sv
// Packet header serializer: takes one descriptor per handshake and streams the header image
// (up to 128 bytes) onto a 512-bit AXI-Stream as one or two beats. For the last packet of a
// WQE it then presents one completion record.
module pkt_hdr_serializer #(
    parameter int unsigned PKT_DESC_WIDTH         = 1024,
    parameter int unsigned PKT_DESC_HDR_LEN_WIDTH = 8,
    parameter int unsigned AXIS_DATA_WIDTH        = 512,
    parameter int unsigned QP_PTR_WIDTH           = 5,
    parameter int unsigned PKT_CNT_WIDTH          = 32,
    parameter int unsigned ERR_CNT_WIDTH          = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_pkt_desc_valid,
    output logic                              o_pkt_desc_ready,
    input  logic [PKT_DESC_HDR_LEN_WIDTH-1:0] i_pkt_desc_hdr_len,
    input  logic [PKT_DESC_WIDTH-1:0]         i_pkt_desc,
    input  logic                              i_final,
    input  logic [QP_PTR_WIDTH-1:0]           i_qpn,
    input  logic [63:0]                       i_wr_id,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]      m_axis_tkeep,
    output logic                              m_axis_tlast,
    output logic                              o_cpl_valid,
    input  logic                              i_cpl_ready,
    output logic [QP_PTR_WIDTH-1:0]           o_cpl_qpn,
    output logic [63:0]                       o_cpl_wr_id,
    output logic [PKT_CNT_WIDTH-1:0]          o_pkt_cnt,
    output logic [ERR_CNT_WIDTH-1:0]          o_err_cnt
);

    localparam int unsigned KeepWidth = AXIS_DATA_WIDTH / 8;
    localparam logic [PKT_DESC_HDR_LEN_WIDTH-1:0] BeatLen =
        PKT_DESC_HDR_LEN_WIDTH'(AXIS_DATA_WIDTH / 8);
    localparam logic [PKT_DESC_HDR_LEN_WIDTH-1:0] MaxLen =
        PKT_DESC_HDR_LEN_WIDTH'(PKT_DESC_WIDTH / 8);

    typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StCpl} state_e;

    state_e                            state_q, state_d;
    logic [PKT_DESC_WIDTH-1:0]         desc_q, desc_d;
    logic [PKT_DESC_HDR_LEN_WIDTH-1:0] len_q, len_d;
    logic                              final_q, final_d;
    logic [QP_PTR_WIDTH-1:0]           qpn_q, qpn_d;
    logic [63:0]                       wr_id_q, wr_id_d;
    logic [PKT_CNT_WIDTH-1:0]          pkt_cnt_q, pkt_cnt_d;
    logic [ERR_CNT_WIDTH-1:0]          err_cnt_q, err_cnt_d;
    logic [ERR_CNT_WIDTH-1:0]          err_cnt_sat;

    // Saturating increment of the malformed-descriptor counter
    assign err_cnt_sat = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;

    // State and captured-descriptor registers; reset abandons any packet in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            desc_q    <= '0;
            len_q     <= '0;
            final_q   <= 1'b0;
            qpn_q     <= '0;
            wr_id_q   <= '0;
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            desc_q    <= desc_d;
            len_q     <= len_d;
            final_q   <= final_d;
            qpn_q     <= qpn_d;
            wr_id_q   <= wr_id_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Next-state, descriptor capture and counter updates
    always_comb begin
        state_d   = state_q;
        desc_d    = desc_q;
        len_d     = len_q;
        final_d   = final_q;
        qpn_d     = qpn_q;
        wr_id_d   = wr_id_q;
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (i_pkt_desc_valid) begin
                    desc_d  = i_pkt_desc;
                    final_d = i_final;
                    qpn_d   = i_qpn;
                    wr_id_d = i_wr_id;
                    if (i_pkt_desc_hdr_len == '0) begin
                        // Empty header: nothing to send, but a final packet still completes
                        err_cnt_d = err_cnt_sat;
                        len_d     = '0;
                        state_d   = i_final ? StCpl : StIdle;
                    end else begin
                        if (i_pkt_desc_hdr_len > MaxLen) begin
                            err_cnt_d = err_cnt_sat;
                            len_d     = MaxLen;
                        end else begin
                            len_d = i_pkt_desc_hdr_len;
                        end
                        state_d = StBeat0;
                    end
                end
            end
            StBeat0: begin
                if (m_axis_tready) begin
                    if (len_q <= BeatLen) begin
                        pkt_cnt_d = pkt_cnt_q + 1'b1;
                        state_d   = final_q ? StCpl : StIdle;
                    end else begin
                        state_d = StBeat1;
                    end
                end
            end
            StBeat1: begin
                if (m_axis_tready) begin
                    pkt_cnt_d = pkt_cnt_q + 1'b1;
                    state_d   = final_q ? StCpl : StIdle;
                end
            end
            StCpl: begin
                if (i_cpl_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Stream outputs decoded from the state and captured descriptor, so they hold during stalls
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        unique case (state_q)
            StBeat0: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = desc_q[AXIS_DATA_WIDTH-1:0];
                if (len_q <= BeatLen) begin
                    m_axis_tlast = 1'b1;
                    for (int i = 0; i < int'(KeepWidth); i++) begin
                        m_axis_tkeep[i] = (i < int'(len_q));
                    end
                end else begin
                    m_axis_tkeep = '1;
                end
            end
            StBeat1: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = desc_q[2*AXIS_DATA_WIDTH-1:AXIS_DATA_WIDTH];
                m_axis_tlast  = 1'b1;
                for (int i = 0; i < int'(KeepWidth); i++) begin
                    m_axis_tkeep[i] = (i + int'(KeepWidth) < int'(len_q));
                end
            end
            default: ;
        endcase
    end

    assign o_pkt_desc_ready = (state_q == StIdle);
    assign o_cpl_valid      = (state_q == StCpl);
    assign o_cpl_qpn        = qpn_q;
    assign o_cpl_wr_id      = wr_id_q;
    assign o_pkt_cnt        = pkt_cnt_q;
    assign o_err_cnt        = err_cnt_q;

endmodule
